acc_seq: RTL and testbench
==========================

# acc_seq

Job sequencer for the matrix accelerator (`top_acc`). It sits between the accelerator's APB register file and the accelerator core. The APB side issues start/abort commands and reads back the results; this block turns each accepted command into a one-cycle `acc_start` pulse and waits for `acc_done`. While waiting it measures job latency, enforces an optional timeout, keeps sticky status flags and a completed-job count, and raises a level interrupt.

## Interface
- `CNT_WIDTH`, default 16: width of the cycle counter, the timeout value and the job counter.
- `HCLK  in  1`: clock; all state updates on the rising edge.
- `HRESET  in  1`: asynchronous, active-high reset.
- `cmd_start  in  1`: single-cycle start command from the register write decode.
- `cmd_abort  in  1`: single-cycle abort command.
- `irq_en  in  1`: interrupt enable (level).
- `irq_clr  in  1`: single-cycle interrupt clear.
- `cfg_timeout  in  CNT_WIDTH`: timeout in WAIT cycles; 0 disables the timeout.
- `acc_done  in  1`: completion signal from the accelerator.
- `acc_start  out  1`: registered start pulse to the accelerator.
- `busy  out  1`: high when the state is not IDLE.
- `status_done  out  1`: sticky, last job completed.
- `status_timeout  out  1`: sticky, last job timed out.
- `status_abort  out  1`: sticky, last job aborted.
- `cycle_cnt  out  CNT_WIDTH`: WAIT cycles of the last/current job, saturating.
- `job_cnt  out  CNT_WIDTH`: count of completed jobs, wraps modulo 2^CNT_WIDTH.
- `irq  out  1`: level interrupt.

## Operation
- States are IDLE, START, WAIT. Reset state is IDLE.
- Reset values: every output is 0, including `acc_start`, `busy`, all status flags, `cycle_cnt`, `job_cnt` and `irq`.
- **IDLE:**
  - `cmd_start`=1 moves to START.
  - The same edge clears all three status flags and `cycle_cnt`.
  - `cmd_abort` in IDLE is ignored. `cmd_start` and `cmd_abort` together in IDLE: the start is taken.
- **START:**
  - Lasts exactly one cycle; `acc_start`=1 only in this state.
  - `acc_done` is ignored in this state.
  - `cmd_abort`=1 moves to IDLE and sets `status_abort`.
  - Otherwise moves to WAIT.
- **WAIT:** each cycle, let `n` = `cycle_cnt`+1, saturated at 2^CNT_WIDTH-1. `cycle_cnt` <= `n`. Then evaluate in this priority order:
  1. `acc_done`=1: go to IDLE, set `status_done`, increment `job_cnt`.
  2. `cmd_abort`=1: go to IDLE, set `status_abort`.
  3. `cfg_timeout`!=0 and `n`==`cfg_timeout`: go to IDLE, set `status_timeout`.
  4. Otherwise stay in WAIT.
- `cmd_start` while `busy`=1 is ignored and has no side effects.
- **Interrupt:**
  - `irq` is set on the edge that leaves WAIT or START with any status flag being set, provided `irq_en`=1.
  - `irq` is cleared by `irq_clr`.
  - A set and a clear in the same cycle: the set wins.
  - `irq_en`=0 does not clear a pending `irq`.
- A timeout or abort does not reset the accelerator. A `cmd_start` issued after a timeout restarts it; recovery of the core is software's responsibility.
- A counter at saturation holds at 2^CNT_WIDTH-1. With the timeout disabled, WAIT lasts indefinitely.

## Timing
- `cmd_start` sampled at edge k: START at k+1 (`acc_start` high for cycle k+1), WAIT from k+2.
- A done sampled in the first WAIT cycle gives `cycle_cnt`=1. Minimum job length is 3 cycles from `cmd_start` to IDLE.
- Status flags, `job_cnt`, `irq` and `busy`=0 all update on the same edge that returns to IDLE. A new `cmd_start` is accepted on the very next cycle.
- With `cfg_timeout`=T and no done, the timeout flag is set on the edge ending the T-th WAIT cycle. `cycle_cnt` then reads T.
- `HRESET` asserted mid-job: all state and outputs go to their reset values immediately. `acc_start` drops asynchronously.

## Test plan
- Normal job: `cmd_start` at cycle 0, `acc_done` pulsed at cycle 6, `irq_en`=1. Expect `acc_start` high only in cycle 1; `cycle_cnt`=5, `status_done`=1, `job_cnt`=1 and `irq`=1 after cycle 6; `busy` low from cycle 7.
- Timeout: `cfg_timeout`=4, `acc_done` never asserted. Expect IDLE after 4 WAIT cycles, `status_timeout`=1, `cycle_cnt`=4, `job_cnt` unchanged.
- Simultaneous events in WAIT: `acc_done`, `cmd_abort` and the timeout all in one cycle. Expect only `status_done`=1.
- Abort in START: expect `status_abort`=1, no WAIT entered, `cycle_cnt`=0.
- Counters: with `CNT_WIDTH`=4, run 16 jobs and expect `job_cnt` to wrap to 0. With `cfg_timeout`=0 and a 20-cycle job, expect `cycle_cnt` to saturate at 15.
- Interrupt and reset corners:
  - `irq_clr` in the same cycle as a completion: `irq` stays 1.
  - `cmd_start` while `busy`: ignored.
  - `HRESET` in WAIT: all outputs 0 immediately.

Source files
------------

// File: rtl/acc_seq.sv
// Job sequencer: turns start/abort commands into an accelerator start pulse, tracks
// latency, timeout, sticky status, completed-job count and a level interrupt.
module acc_seq #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic                 irq_en,
    input  logic                 irq_clr,
    input  logic [CNT_WIDTH-1:0] cfg_timeout,
    input  logic                 acc_done,
    output logic                 acc_start,
    output logic                 busy,
    output logic                 status_done,
    output logic                 status_timeout,
    output logic                 status_abort,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] job_cnt,
    output logic                 irq
);

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    state_e               state_q, state_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic                 abt_q, abt_d;
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0] job_cnt_q, job_cnt_d;
    logic                 irq_q, irq_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 job_end;

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        tmo_d       = tmo_q;
        abt_d       = abt_q;
        cycle_cnt_d = cycle_cnt_q;
        job_cnt_d   = job_cnt_q;
        job_end     = 1'b0;
        cnt_inc     = (cycle_cnt_q == CntMax) ? cycle_cnt_q : cycle_cnt_q + CNT_WIDTH'(1);

        case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    state_d     = StStart;
                    done_d      = 1'b0;
                    tmo_d       = 1'b0;
                    abt_d       = 1'b0;
                    cycle_cnt_d = '0;
                end
            end
            StStart: begin
                if (cmd_abort) begin
                    state_d = StIdle;
                    abt_d   = 1'b1;
                    job_end = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cycle_cnt_d = cnt_inc;
                // Completion beats abort, abort beats timeout.
                if (acc_done) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    job_cnt_d = job_cnt_q + CNT_WIDTH'(1);
                    job_end   = 1'b1;
                end else if (cmd_abort) begin
                    state_d = StIdle;
                    abt_d   = 1'b1;
                    job_end = 1'b1;
                end else if ((cfg_timeout != '0) && (cnt_inc == cfg_timeout)) begin
                    state_d = StIdle;
                    tmo_d   = 1'b1;
                    job_end = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Set has priority over clear.
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (job_end && irq_en) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= StIdle;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            abt_q       <= 1'b0;
            cycle_cnt_q <= '0;
            job_cnt_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            abt_q       <= abt_d;
            cycle_cnt_q <= cycle_cnt_d;
            job_cnt_q   <= job_cnt_d;
            irq_q       <= irq_d;
        end
    end

    assign acc_start      = (state_q == StStart);
    assign busy           = (state_q != StIdle);
    assign status_done    = done_q;
    assign status_timeout = tmo_q;
    assign status_abort   = abt_q;
    assign cycle_cnt      = cycle_cnt_q;
    assign job_cnt        = job_cnt_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_acc_seq.sv
// Directed bench for acc_seq: expected job results are queued at issue time and
// compared when the sequencer returns to idle.
module tb_acc_seq;

    localparam int unsigned W = 4;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic         cmd_start, cmd_abort, irq_en, irq_clr, acc_done;
    logic [W-1:0] cfg_timeout;
    logic         acc_start, busy, status_done, status_timeout, status_abort, irq;
    logic [W-1:0] cycle_cnt, job_cnt;

    typedef struct packed {
        logic         done;
        logic         tmo;
        logic         abt;
        logic [W-1:0] cyc;
        logic [W-1:0] job;
        logic         irq;
    } res_t;

    res_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    acc_seq #(.CNT_WIDTH(W)) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .cmd_start     (cmd_start),
        .cmd_abort     (cmd_abort),
        .irq_en        (irq_en),
        .irq_clr       (irq_clr),
        .cfg_timeout   (cfg_timeout),
        .acc_done      (acc_done),
        .acc_start     (acc_start),
        .busy          (busy),
        .status_done   (status_done),
        .status_timeout(status_timeout),
        .status_abort  (status_abort),
        .cycle_cnt     (cycle_cnt),
        .job_cnt       (job_cnt),
        .irq           (irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic d, input logic t, input logic a, input int cyc,
                        input int job, input logic i);
        res_t r;
        r.done = d;
        r.tmo  = t;
        r.abt  = a;
        r.cyc  = W'(cyc);
        r.job  = W'(job);
        r.irq  = i;
        sb.push_back(r);
    endtask

    task automatic collect(input string tag);
        res_t e;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".done"}, {31'd0, status_done}, {31'd0, e.done});
            chk({tag, ".timeout"}, {31'd0, status_timeout}, {31'd0, e.tmo});
            chk({tag, ".abort"}, {31'd0, status_abort}, {31'd0, e.abt});
            chk({tag, ".cycle_cnt"}, {28'd0, cycle_cnt}, {28'd0, e.cyc});
            chk({tag, ".job_cnt"}, {28'd0, job_cnt}, {28'd0, e.job});
            chk({tag, ".irq"}, {31'd0, irq}, {31'd0, e.irq});
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".acc_start"}, {31'd0, acc_start}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".flags"}, {29'd0, status_done, status_timeout, status_abort}, 32'd0);
        chk({tag, ".cycle_cnt"}, {28'd0, cycle_cnt}, 32'd0);
        chk({tag, ".job_cnt"}, {28'd0, job_cnt}, 32'd0);
        chk({tag, ".irq"}, {31'd0, irq}, 32'd0);
    endtask

    initial begin
        HRESET      = 1'b1;
        cmd_start   = 1'b0;
        cmd_abort   = 1'b0;
        irq_en      = 1'b1;
        irq_clr     = 1'b0;
        acc_done    = 1'b0;
        cfg_timeout = '0;
        #12;
        chk_all_zero("reset");
        HRESET = 1'b0;
        tick();

        // Normal job: done on the 5th WAIT cycle.
        push(1, 0, 0, 5, 1, 1);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk("normal.acc_start_c1", {31'd0, acc_start}, 32'd1);
        chk("normal.busy_c1", {31'd0, busy}, 32'd1);
        tick();
        chk("normal.acc_start_c2", {31'd0, acc_start}, 32'd0);
        repeat (4) tick();
        chk("normal.acc_start_c6", {31'd0, acc_start}, 32'd0);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        collect("normal");

        // Timeout of 4 with irq_en low: pending irq must survive.
        irq_en      = 1'b0;
        cfg_timeout = 4'd4;
        push(0, 1, 0, 4, 1, 1);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        tick();
        repeat (3) tick();
        chk("tmo.busy_before", {31'd0, busy}, 32'd1);
        chk("tmo.cycle_cnt_before", {28'd0, cycle_cnt}, 32'd3);
        tick();
        collect("tmo");
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("tmo.irq_cleared", {31'd0, irq}, 32'd0);

        // Done, abort and timeout coincide: done wins.
        irq_en      = 1'b1;
        cfg_timeout = 4'd2;
        push(1, 0, 0, 2, 2, 1);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        tick();
        tick();
        acc_done  = 1'b1;
        cmd_abort = 1'b1;
        tick();
        acc_done  = 1'b0;
        cmd_abort = 1'b0;
        collect("simul");

        // Start while busy ignored; irq_clr with completion keeps irq.
        cfg_timeout = '0;
        push(1, 0, 0, 2, 3, 1);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        tick();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk("busy_start.acc_start", {31'd0, acc_start}, 32'd0);
        acc_done = 1'b1;
        irq_clr  = 1'b1;
        tick();
        acc_done = 1'b0;
        irq_clr  = 1'b0;
        collect("clr_set");
        tick();
        chk("busy_start.no_restart", {31'd0, busy}, 32'd0);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("irq_clr", {31'd0, irq}, 32'd0);

        // Start+abort in IDLE takes the start; abort in START.
        push(0, 0, 1, 0, 3, 1);
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        chk("abort.start_taken", {31'd0, acc_start}, 32'd1);
        chk("abort.flags_cleared", {29'd0, status_done, status_timeout, status_abort}, 32'd0);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        collect("abort_start");
        tick();
        chk("abort.no_wait", {31'd0, busy}, 32'd0);

        // 20 WAIT cycles with no timeout: cycle_cnt saturates.
        push(1, 0, 0, 15, 4, 1);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        tick();
        repeat (19) tick();
        chk("sat.busy", {31'd0, busy}, 32'd1);
        chk("sat.cycle_cnt", {28'd0, cycle_cnt}, 32'd15);
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        collect("sat");

        // Back-to-back minimum jobs until job_cnt wraps to 0.
        for (int k = 5; k <= 16; k++) begin
            push(1, 0, 0, 1, k % 16, 1);
            cmd_start = 1'b1;
            tick();
            cmd_start = 1'b0;
            tick();
            acc_done = 1'b1;
            tick();
            acc_done = 1'b0;
            collect("wrap");
        end

        // Asynchronous reset in START and in WAIT.
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk("rst_start.acc_start_pre", {31'd0, acc_start}, 32'd1);
        #2;
        HRESET = 1'b1;
        #1;
        chk_all_zero("rst_start");
        HRESET = 1'b0;
        tick();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        repeat (3) tick();
        chk("rst_wait.cycle_cnt_pre", {28'd0, cycle_cnt}, 32'd2);
        #2;
        HRESET = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        HRESET = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
